fetch_pc_queue: RTL

Instruction-fetch stage that owns the fetch PC, drives it to the I-cache and to `branch_pred`, and picks the next PC from the predictor's `pred_o`/`btb_target_o`. Each fetched instruction is buffered in a small in-order queue together with its prediction and then handed to decode under a valid/ready handshake. The execute stage can force a mispredict redirect, which flushes the queue and restarts fetch at the corrected PC.

---
 rtl/fetch_pc_queue_if.sv | 35 +++
 rtl/fetch_pc_queue.sv | 74 +++++++
 2 files changed

// File: rtl/fetch_pc_queue_if.sv
// fetch_pc_queue_if: fetch-stage bus grouping I-cache, predictor, execute redirect and decode handshake.
// master: fetch stage (drives PC, request, decode head); slave: surrounding pipeline/testbench.
interface fetch_pc_queue_if #(
    parameter int DEPTH = 4
);
    logic [63:0]            if_pc_o;
    logic                   icache_req_o;
    logic                   icache_valid_i;
    logic [31:0]            icache_data_i;
    logic                   bp_pred_i;
    logic [63:0]            bp_target_i;
    logic                   ex_mispred_i;
    logic [63:0]            ex_redirect_pc_i;
    logic                   id_valid_o;
    logic                   id_ready_i;
    logic [63:0]            id_pc_o;
    logic [31:0]            id_inst_o;
    logic                   id_pred_taken_o;
    logic [63:0]            id_pred_target_o;
    logic [$clog2(DEPTH):0] count_o;

    modport master (
        output if_pc_o, icache_req_o, id_valid_o, id_pc_o, id_inst_o,
               id_pred_taken_o, id_pred_target_o, count_o,
        input  icache_valid_i, icache_data_i, bp_pred_i, bp_target_i,
               ex_mispred_i, ex_redirect_pc_i, id_ready_i
    );

    modport slave (
        input  if_pc_o, icache_req_o, id_valid_o, id_pc_o, id_inst_o,
               id_pred_taken_o, id_pred_target_o, count_o,
        output icache_valid_i, icache_data_i, bp_pred_i, bp_target_i,
               ex_mispred_i, ex_redirect_pc_i, id_ready_i
    );
endinterface

// File: rtl/fetch_pc_queue.sv
// fetch_pc_queue: fetch PC owner with next-PC selection and an in-order fetch queue feeding decode.
// Ports: clk, rst (async active-low), bus (fetch_pc_queue_if.master: I-cache, predictor, redirect, decode).
module fetch_pc_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic           clk,
    input logic           rst,
    fetch_pc_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   r_pc;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [63:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_q_inst [DEPTH];
    logic          r_q_tk   [DEPTH];
    logic [63:0]   r_q_tgt  [DEPTH];

    logic          w_full;
    logic          w_enq;
    logic          w_deq;
    logic [63:0]   w_npc;

    assign w_full = r_count == CW'(DEPTH);
    // Full blocks enqueue regardless of a same-cycle dequeue, so request never depends on id_ready_i.
    assign bus.icache_req_o = !w_full && !bus.ex_mispred_i;
    assign w_enq = bus.icache_req_o && bus.icache_valid_i;
    assign w_deq = bus.id_valid_o && bus.id_ready_i && !bus.ex_mispred_i;
    assign w_npc = bus.bp_pred_i ? bus.bp_target_i : r_pc + 64'd4;

    assign bus.if_pc_o          = r_pc;
    assign bus.count_o          = r_count;
    assign bus.id_valid_o       = r_count != '0;
    assign bus.id_pc_o          = r_q_pc[r_head];
    assign bus.id_inst_o        = r_q_inst[r_head];
    assign bus.id_pred_taken_o  = r_q_tk[r_head];
    assign bus.id_pred_target_o = r_q_tgt[r_head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_inst[i] <= '0;
                r_q_tk[i]   <= 1'b0;
                r_q_tgt[i]  <= '0;
            end
        end else if (bus.ex_mispred_i) begin
            r_pc    <= bus.ex_redirect_pc_i;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_q_pc[r_tail]   <= r_pc;
                r_q_inst[r_tail] <= bus.icache_data_i;
                r_q_tk[r_tail]   <= bus.bp_pred_i;
                r_q_tgt[r_tail]  <= w_npc;
                r_tail           <= r_tail + 1'b1;
                r_pc             <= w_npc;
            end
            if (w_deq)
                r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end
endmodule
